// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two Avalon-MM-style masters, the arbiter and the RAM s1 slave.
// The slave modport is the arbiter's view; the master modport is the view of the masters and the RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_writedata;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_clken, ram_writedata,
        input  ram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_clken, ram_writedata,
        output ram_readdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port 2048x32 RAM: same-cycle grant, 1-cycle tagged read return.
// Define RAM_ARB_RR_EN for round-robin re-arbitration; the default build uses fixed priority (M0 first).
module ram_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic valid;
        logic tag;
    } rd_pend_t;

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_grant_q, last_grant_d;
    rd_pend_t         rd_pend_q, rd_pend_d;

    logic req0, req1;
    logic gnt0, gnt1;
    logic keep0, keep1;
    logic burst_open;
    owner_e new_owner;

    always_comb begin
        req0       = bus.m0_read | bus.m0_write;
        req1       = bus.m1_read | bus.m1_write;
        burst_open = (burst_cnt_q < BURST_LIM);
        keep0      = (owner_q == OWN_M0) && req0 && (!req1 || burst_open);
`ifdef RAM_ARB_RR_EN
        keep1      = (owner_q == OWN_M1) && req1 && (!req0 || burst_open);
`else
        // Under fixed priority M1 never extends its tenure while M0 is waiting.
        keep1      = (owner_q == OWN_M1) && req1 && !req0;
`endif
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (keep0) begin
            gnt0 = 1'b1;
        end else if (keep1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
`else
            // Reaching here with M0 as owner means its burst is exhausted.
            gnt1 = (owner_q == OWN_M0);
            gnt0 = (owner_q != OWN_M0);
`endif
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        bus.m0_waitrequest = !reset_n || (req0 && !gnt0);
        bus.m1_waitrequest = !reset_n || (req1 && !gnt1);
        bus.ram_clken      = reset_n;
        bus.ram_chipselect = gnt0 | gnt1;
        bus.ram_write      = 1'b0;
        bus.ram_address    = '0;
        bus.ram_byteenable = '0;
        bus.ram_writedata  = '0;
        if (gnt0) begin
            bus.ram_write      = bus.m0_write;
            bus.ram_address    = bus.m0_address;
            bus.ram_byteenable = bus.m0_write ? bus.m0_byteenable : {BE_W{1'b1}};
            bus.ram_writedata  = bus.m0_writedata;
        end else if (gnt1) begin
            bus.ram_write      = bus.m1_write;
            bus.ram_address    = bus.m1_address;
            bus.ram_byteenable = bus.m1_write ? bus.m1_byteenable : {BE_W{1'b1}};
            bus.ram_writedata  = bus.m1_writedata;
        end
        bus.m0_readdata      = bus.ram_readdata;
        bus.m1_readdata      = bus.ram_readdata;
        bus.m0_readdatavalid = rd_pend_q.valid && !rd_pend_q.tag;
        bus.m1_readdatavalid = rd_pend_q.valid &&  rd_pend_q.tag;
    end

    always_comb begin
        new_owner    = gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : OWN_NONE);
        owner_d      = new_owner;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
            if (new_owner != owner_q) begin
                burst_cnt_d = CNT_W'(1);
            end else if (burst_open) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end
        rd_pend_d.valid = (gnt0 && !bus.m0_write) || (gnt1 && !bus.m1_write);
        rd_pend_d.tag   = gnt1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= OWN_NONE;
            burst_cnt_q  <= '0;
            last_grant_q <= 1'b1;
            rd_pend_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 2048x32 RAM; expectations follow the build's arbitration mode.
module tb_ram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:2047];
    logic [31:0] ram_rd;

    always @(posedge clk) begin
        if (bus.ram_clken && bus.ram_chipselect) begin
            if (bus.ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byteenable[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
            end else begin
                ram_rd <= mem[bus.ram_address];
            end
        end
    end
    assign bus.ram_readdata = ram_rd;

    int total = 0;
    int bad   = 0;
    int prev_g;
    logic [31:0] prev_d;
    int exp_con [12];
    int exp_idle [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_masters();
        bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_writedata = '0;
        bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_writedata = '0;
    endtask

    task automatic reset_dut();
        idle_masters();
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        prev_g = 2;
        prev_d = '0;
    endtask

    // One cycle of reads; exp_g is 0/1 for the master to be granted, 2 for none.
    task automatic step(input bit r0, input bit r1, input logic [10:0] a0, input logic [10:0] a1,
                        input int exp_g, input logic [31:0] exp_d, input string tag);
        int g;
        bus.m0_read = r0; bus.m0_write = 1'b0; bus.m0_address = a0; bus.m0_byteenable = '0;
        bus.m1_read = r1; bus.m1_write = 1'b0; bus.m1_address = a1; bus.m1_byteenable = '0;
        @(negedge clk);
        g = (r0 && !bus.m0_waitrequest) ? 0 : ((r1 && !bus.m1_waitrequest) ? 1 : 2);
        check({tag, "_grant"}, g, exp_g);
        if (!r0) check({tag, "_wr0_idle"}, bus.m0_waitrequest, 1'b0);
        if (!r1) check({tag, "_wr1_idle"}, bus.m1_waitrequest, 1'b0);
        if (exp_g != 2) check({tag, "_be_forced"}, bus.ram_byteenable, 4'hF);
        check({tag, "_rdv0"}, bus.m0_readdatavalid, prev_g == 0);
        check({tag, "_rdv1"}, bus.m1_readdatavalid, prev_g == 1);
        if (prev_g != 2) check({tag, "_rdata"}, bus.m0_readdata, prev_d);
        prev_g = exp_g;
        prev_d = exp_d;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input int k, input logic [10:0] a, input logic [3:0] be,
                            input logic [31:0] d, input string tag);
        if (k == 0) begin
            bus.m0_write = 1'b1; bus.m0_read = 1'b0; bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = d;
        end else begin
            bus.m1_write = 1'b1; bus.m1_read = 1'b0; bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = d;
        end
        @(negedge clk);
        check({tag, "_wait"}, (k == 0) ? bus.m0_waitrequest : bus.m1_waitrequest, 1'b0);
        check({tag, "_ram_write"}, bus.ram_write, 1'b1);
        check({tag, "_ram_addr"}, bus.ram_address, a);
        check({tag, "_ram_be"}, bus.ram_byteenable, be);
        check({tag, "_ram_wdata"}, bus.ram_writedata, d);
        prev_g = 2;
        @(posedge clk); #1;
        idle_masters();
    endtask

    initial begin
        int n0, n1;
        logic [10:0] a0, a1;
`ifdef RAM_ARB_RR_EN
        exp_con  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        exp_idle = '{1, 1, 1, 0, 0};
`else
        exp_con  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        exp_idle = '{0, 0, 0, 0, 1};
`endif
        for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | i;
        mem[11'h7FF] <= 32'h1122_3344;
        ram_rd <= '0;
        idle_masters();
        reset_n = 1'b0;

        // Reset state with commands already pending.
        bus.m0_read  = 1'b1;
        bus.m1_write = 1'b1;
        @(negedge clk);
        check("rst_wait0", bus.m0_waitrequest, 1'b1);
        check("rst_wait1", bus.m1_waitrequest, 1'b1);
        check("rst_cs", bus.ram_chipselect, 1'b0);
        check("rst_clken", bus.ram_clken, 1'b0);
        check("rst_ram_write", bus.ram_write, 1'b0);
        check("rst_rdv", {bus.m0_readdatavalid, bus.m1_readdatavalid}, 2'b00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_masters();
        prev_g = 2;
        prev_d = '0;

        // Write then read back on M0 straight after reset release.
        do_write(0, 11'h005, 4'hF, 32'hDEAD_BEEF, "t1_wr");
        check("t1_clken", bus.ram_clken, 1'b1);
        step(1'b1, 1'b0, 11'h005, 11'h000, 0, 32'hDEAD_BEEF, "t1_rd");
        step(1'b0, 1'b0, 11'h000, 11'h000, 2, 32'h0, "t1_ret");

        // Single byte lane write from M1.
        do_write(1, 11'h7FF, 4'h1, 32'h0000_00AA, "t2_wr");
        step(1'b0, 1'b1, 11'h000, 11'h7FF, 1, 32'h1122_33AA, "t2_rd");
        step(1'b0, 1'b0, 11'h000, 11'h000, 2, 32'h0, "t2_ret");

        // Both masters stream reads.
        reset_dut();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            a0 = 11'h100 + 11'(n0);
            a1 = 11'h200 + 11'(n1);
            step(1'b1, 1'b1, a0, a1, exp_con[i],
                 32'hA500_0000 | ((exp_con[i] == 0) ? 32'(a0) : 32'(a1)), $sformatf("con%0d", i));
            if (exp_con[i] == 0) n0++; else n1++;
        end
        step(1'b0, 1'b0, 11'h000, 11'h000, 2, 32'h0, "con_ret");

        // Owner drops out after two grants.
        reset_dut();
        step(1'b1, 1'b1, 11'h010, 11'h020, 0, 32'hA500_0010, "idl0");
        step(1'b1, 1'b1, 11'h011, 11'h020, 0, 32'hA500_0011, "idl1");
        step(1'b0, 1'b1, 11'h000, 11'h020, 1, 32'hA500_0020, "idl2");
        n0 = 0; n1 = 1;
        for (int i = 0; i < 5; i++) begin
            a0 = 11'h012 + 11'(n0);
            a1 = 11'h020 + 11'(n1);
            step(1'b1, 1'b1, a0, a1, exp_idle[i],
                 32'hA500_0000 | ((exp_idle[i] == 0) ? 32'(a0) : 32'(a1)), $sformatf("idl%0d", i + 3));
            if (exp_idle[i] == 0) n0++; else n1++;
        end
        step(1'b0, 1'b0, 11'h000, 11'h000, 2, 32'h0, "idl_ret");

        // Reset lands while a read is in flight.
        reset_dut();
        step(1'b1, 1'b0, 11'h030, 11'h000, 0, 32'hA500_0030, "rr_issue");
        reset_n = 1'b0;
        bus.m0_read = 1'b1;
        bus.m1_read = 1'b1;
        @(negedge clk);
        check("rr_rdv", {bus.m0_readdatavalid, bus.m1_readdatavalid}, 2'b00);
        check("rr_wait", {bus.m0_waitrequest, bus.m1_waitrequest}, 2'b11);
        check("rr_cs", bus.ram_chipselect, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        prev_g = 2;
        step(1'b1, 1'b1, 11'h031, 11'h040, 0, 32'hA500_0031, "rr_first");
        step(1'b0, 1'b0, 11'h000, 11'h000, 2, 32'h0, "rr_ret");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 2048x32 on-chip RAM between two Avalon-MM-style masters. Each master holds its command until `waitrequest` is low. The arbiter issues at most one RAM access per cycle and returns read data one cycle after issue, tagged to the master that requested it. A burst counter keeps the current owner granted for consecutive accesses, which limits owner switching. It sits between the CPU data master, the DMA/peripheral master and the RAM's `s1` slave.

## Interface
- `ADDR_W`, 11, RAM word-address width.
- `DATA_W`, 32, data width. Must be a multiple of 8.
- `BE_W`, `DATA_W/8`, byte-enable width.
- `BURST_MAX`, 4, maximum consecutive grants to one owner while the other master waits. Must be ≥1.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mK_address` (K=0,1)  in  ADDR_W  word address.
- `mK_byteenable`  in  BE_W  byte lanes for a write. Ignored on a read.
- `mK_read` / `mK_write`  in  1 each  command request. Both high is treated as a write.
- `mK_writedata`  in  DATA_W  write data.
- `mK_waitrequest`  out  1  high while the command is not accepted this cycle.
- `mK_readdata`  out  DATA_W  read data, valid only when `mK_readdatavalid` is high.
- `mK_readdatavalid`  out  1  one-cycle pulse marking returned read data.
- `ram_address`  out  ADDR_W.
- `ram_byteenable`  out  BE_W.
- `ram_chipselect`, `ram_write`, `ram_clken`  out  1 each.
- `ram_writedata`  out  DATA_W.
- `ram_readdata`  in  DATA_W  valid one cycle after the read is issued (input is registered, output is not).

## Operation
- Registered state:
  - `owner`: NONE, M0 or M1.
  - `burst_cnt`: width clog2(BURST_MAX+1), saturating.
  - `last_grant`: 0 or 1.
  - `rd_pend`: valid bit plus master tag.
- Request: `reqK = mK_read | mK_write`.
- Grant is combinational from the registered state and the current requests, so it is decided in the same cycle.
  - Keep the owner if it still requests AND (the other master is idle OR `burst_cnt < BURST_MAX`).
  - Otherwise re-arbitrate among the requesters.
  - If there are no requests, grant nobody and set `owner` to NONE.
- Re-arbitration policy is set under Configuration.
- On a grant to master K:
  - `mK_waitrequest=0`, `ram_chipselect=1`.
  - `ram_write=mK_write`.
  - Address, byteenable and writedata are muxed from master K.
  - For a read, `ram_byteenable` is forced to all ones.
- A non-granted requester sees `waitrequest=1`.
- `waitrequest=0` whenever the master is not requesting.
- `burst_cnt` updates on each granted transfer:
  - Set to 1 when ownership changes or is newly taken.
  - Otherwise increments, saturating at `BURST_MAX`.
- A granted read sets `rd_pend={1,K}` for the next cycle. A write or idle cycle clears it.
- `mK_readdatavalid = rd_pend.valid & (rd_pend.tag==K)`, as a registered output.
- `mK_readdata = ram_readdata` for both masters, passed through unconditionally.
- `ram_clken` is 1 constantly out of reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `owner=NONE`, `burst_cnt=0`, `last_grant=1` (so M0 wins first), `rd_pend` invalid.
  - All `readdatavalid` low.
  - All `ram_*` outputs 0, including `ram_clken`.
  - `mK_waitrequest=1` while `reset_n` is low.
- Write latency: 0. The write is complete in the cycle `waitrequest` is low.
- Read latency: 1. Issue in cycle N; data and `readdatavalid` in cycle N+1.
- Back-to-back issue every cycle is allowed. A read return in N+1 overlaps a new issue in N+1 at full throughput.
- Reset asserted with a read pending: the return is dropped and no `readdatavalid` is emitted.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin.
  - When both masters request at re-arbitration, grant the master that is not `last_grant`.
  - `last_grant` updates on every grant.
- `RAM_ARB_RR_EN` undefined: fixed priority.
  - M0 always wins re-arbitration.
  - M1 is granted only when M0 is idle or its burst expires.
  - When both keep requesting, M0 regains ownership after M1's single grant: `BURST_MAX` M0 accesses, then 1 M1 access, repeating.

## Test plan
- **Reset release:** M0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF. Next cycle M0 reads 0x005. Required: `m0_waitrequest=0` both cycles, and `m0_readdatavalid` with data 0xDEADBEEF one cycle after the read.
- **Byte lanes:** M1 writes 0x000000AA with byteenable 0x1 to address 0x7FF, which already holds 0x11223344. Read back. Required: 0x112233AA.
- **Contention, RR build, `BURST_MAX=4`:** both masters stream reads continuously. Required: grant sequence M0×4, M1×4, M0×4, and every `readdatavalid` goes to the correct master one cycle after its issue.
- **Fixed-priority build, same stimulus:** required pattern M0×4, M1×1, M0×4.
- **Owner goes idle mid-burst:** M0 drops its request after 2 grants while M1 requests. Required: M1 is granted the next cycle and `burst_cnt` restarts at 1.
- **Reset during read:** assert `reset_n` low in the cycle after a read issue. Required: no `readdatavalid`, all `waitrequest=1`, and the first grant after release goes to M0.
